// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, next-PC selection (jr, branch, j/jal, sequential)
// and a BOOT/RUN/HALT/FAULT control FSM. RESET_PC[1:0] must be zero.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [31:0] Instruction,
  input  logic        BranchTaken,
  input  logic        JumpReg,
  input  logic [31:0] JrTarget,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        FetchValid,
  output logic        Halted,
  output logic        Fault
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 6;
  localparam int unsigned IMMW   = 16;
  localparam int unsigned JIDXW  = 26;

  localparam logic [OPW-1:0] OP_J   = 6'h02;
  localparam logic [OPW-1:0] OP_JAL = 6'h03;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic [XLEN-1:0]   pc_plus_4;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   j_target;
  logic [OPW-1:0]    opcode;
  logic              is_j;
  logic              jr_misaligned;

  // Candidate fetch targets; all arithmetic wraps modulo 2^32
  always_comb begin
    pc_plus_4     = pc_q + XLEN'(4);
    br_target     = pc_plus_4 + {{(XLEN-IMMW-2){Instruction[IMMW-1]}},
                                 Instruction[IMMW-1:0], 2'b00};
    j_target      = {pc_plus_4[XLEN-1:XLEN-4], Instruction[JIDXW-1:0], 2'b00};
    opcode        = Instruction[XLEN-1:XLEN-OPW];
    is_j          = (opcode == OP_J) || (opcode == OP_JAL);
    jr_misaligned = (JrTarget[1:0] != 2'b00);
  end

  // Next-state and next-PC; jr fault outranks self-jump halt by priority order
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!Stall) begin
          if (JumpReg) begin
            if (jr_misaligned) state_d = ST_FAULT;
            else               pc_d    = JrTarget;
          end else if (BranchTaken) begin
            pc_d = br_target;
          end else if (is_j) begin
            if (j_target == pc_q) state_d = ST_HALT;
            else                  pc_d    = j_target;
          end else begin
            pc_d = pc_plus_4;
          end
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase

    halted_d = (state_d == ST_HALT);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // FetchValid follows the live Stall input so a stalled word is never issued
  assign PC         = pc_q;
  assign PC_plus_4  = pc_plus_4;
  assign FetchValid = (state_q == ST_RUN) && !Stall;
  assign Halted     = halted_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle expectations from a behavioural model are
// queued by the stimulus process and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int BOOT  = 0;
  localparam int RUN   = 1;
  localparam int HALT  = 2;
  localparam int FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0;
  logic [31:0] Instruction = 32'h0;
  logic        BranchTaken = 1'b0;
  logic        JumpReg = 1'b0;
  logic [31:0] JrTarget = 32'h0;
  logic [31:0] PC, PC_plus_4;
  logic        FetchValid, Halted, Fault;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Instruction(Instruction),
    .BranchTaken(BranchTaken), .JumpReg(JumpReg), .JrTarget(JrTarget),
    .PC(PC), .PC_plus_4(PC_plus_4), .FetchValid(FetchValid),
    .Halted(Halted), .Fault(Fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        h;
    logic        f;
  } exp_t;

  exp_t        expq[$];
  int          total = 0;
  int          bad = 0;
  int          m_state = BOOT;
  logic [31:0] m_pc = RESET_PC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      check("pc", PC, e.pc);
      check("pc_plus_4", PC_plus_4, e.pc + 32'd4);
      check("fetch_valid", 32'(FetchValid), 32'(e.fv));
      check("halted", 32'(Halted), 32'(e.h));
      check("fault", 32'(Fault), 32'(e.f));
    end
  end

  // One cycle: called just after a rising edge; drives inputs, queues expectation, advances model
  task automatic step(input logic st, input logic [31:0] ins, input logic br,
                      input logic jr, input logic [31:0] jt);
    exp_t        e;
    logic [31:0] tgt;
    shortint     imm;
    Stall = st; Instruction = ins; BranchTaken = br; JumpReg = jr; JrTarget = jt;
    e.pc = m_pc;
    e.fv = (m_state == RUN) && !st;
    e.h  = (m_state == HALT);
    e.f  = (m_state == FAULT);
    expq.push_back(e);
    if (m_state == BOOT) begin
      m_state = RUN;
    end else if (m_state == RUN && !st) begin
      if (jr) begin
        if (jt % 4 != 0) m_state = FAULT;
        else             m_pc = jt;
      end else if (br) begin
        imm  = shortint'(ins[15:0]);
        m_pc = m_pc + 32'd4 + 32'(int'(imm) * 4);
      end else if (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) begin
        tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (tgt == m_pc) m_state = HALT;
        else             m_pc = tgt;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rand_step();
    logic        st, br, jr;
    logic [31:0] jt, ins;
    int          r;
    st = ($urandom_range(0, 4) == 0);
    br = ($urandom_range(0, 5) == 0);
    jr = ($urandom_range(0, 11) == 0);
    jt = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 5) == 0) jt[1:0] = 2'($urandom_range(1, 3));
    ins = $urandom;
    r = $urandom_range(0, 9);
    if (r == 0)     ins = {6'h02, m_pc[27:2]};
    else if (r < 3) ins[31:26] = ($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03;
    step(st, ins, br, jr, jt);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && expq.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(expq.size()), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge
  task automatic do_reset();
    drain();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_pc", PC, RESET_PC);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    check("rst_fetch_valid", 32'(FetchValid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_state = BOOT;
    m_pc    = RESET_PC;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch after reset
    do_reset();
    idle(6);
    check("seq_pc", PC, 32'h0000_0014);

    // Branch forward, backward, and branch-to-self (not a halt)
    do_reset();
    idle(5);
    step(1'b0, 32'h1000_0001, 1'b1, 1'b0, 32'h0);
    check("br_fwd", PC, 32'h0000_0018);
    step(1'b0, 32'h1000_FFFD, 1'b1, 1'b0, 32'h0);
    check("br_back", PC, 32'h0000_0010);
    step(1'b0, 32'h1000_FFFF, 1'b1, 1'b0, 32'h0);
    check("br_self_pc", PC, 32'h0000_0010);
    check("br_self_nohalt", 32'(Halted), 32'd0);
    idle(2);

    // Stall holds PC and ignores a pulsed branch
    do_reset();
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h0);
    check("stall_pc", PC, 32'h0000_0008);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("stall_release", PC, 32'h0000_000C);

    // Self-jump halt at 0x2C, then toggle Stall with noise
    do_reset();
    idle(12);
    step(1'b0, {6'h02, 26'd11}, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++)
      step(1'(i % 2), $urandom, 1'($urandom), 1'($urandom), $urandom);
    check("halt_flag", 32'(Halted), 32'd1);
    check("halt_pc", PC, 32'h0000_002C);

    // Aligned jr, then misaligned jr faults
    do_reset();
    idle(1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0004);
    check("jr_ok", PC, 32'h0040_0004);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0002);
    for (int i = 0; i < 4; i++)
      step(1'(i % 2), $urandom, 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
    check("fault_flag", 32'(Fault), 32'd1);
    check("fault_pc", PC, 32'h0040_0004);

    // Address wrap, and jal keeping upper PC bits
    do_reset();
    idle(1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle(1);
    check("wrap_pc", PC, 32'h0000_0000);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000_0000);
    step(1'b0, {6'h03, 26'h000_0010}, 1'b0, 1'b0, 32'h0);
    check("jal_pc", PC, 32'h4000_0040);
    idle(2);

    // Randomized segments, each entered through an asynchronous reset
    for (int s = 0; s < 6; s++) begin
      do_reset();
      idle(1);
      for (int i = 0; i < 150; i++) rand_step();
    end

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
